// File: rtl/fx2_ep_scheduler.sv
// Round-robin arbiter for the FX2 slave-FIFO bus across EP2/EP4/EP6/EP8 datapaths.
// Latency: address registered one cycle after selection, grant SETTLE_CYCLES later; all outputs registered.
// Backpressure: a burst closes when the granted endpoint loses eligibility or MAX_BURST bytes have moved.
module fx2_ep_scheduler #(
    parameter int MAX_BURST     = 64,
    parameter int SETTLE_CYCLES = 2,
    parameter int TURN_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       usb_ep2_empty,
    input  logic       usb_ep4_empty,
    input  logic       usb_ep6_full,
    input  logic       usb_ep8_full,
    input  logic [3:0] ep_ready,
    input  logic       xfer,
    output logic [1:0] usb_addr,
    output logic       grant_valid,
    output logic [1:0] grant_ep,
    output logic       bus_drive,
    output logic [7:0] byte_count,
    output logic       usb_pktend,
    output logic       burst_end
);

    localparam logic [7:0] MAX_B    = 8'(MAX_BURST);
    localparam logic [2:0] SETTLE_C = 3'(SETTLE_CYCLES);
    localparam logic [2:0] TURN_C   = 3'(TURN_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, ACTIVE, TURN} state_t;

    state_t     state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic [1:0] last, last_nx;
    logic [3:0] elig;
    logic [1:0] winner;
    logic [8:0] count_sum;
    logic [7:0] count_sat;
    logic       end_cond;
    logic       src_done;

    logic [1:0] addr_nx, gep_nx;
    logic [7:0] bc_nx;
    logic       gv_nx, bd_nx, pkt_nx, be_nx;

    assign elig[0] = !usb_ep2_empty & ep_ready[0];
    assign elig[1] = !usb_ep4_empty & ep_ready[1];
    assign elig[2] = !usb_ep6_full  & ep_ready[2];
    assign elig[3] = !usb_ep8_full  & ep_ready[3];

    // Round-robin pick: first eligible index after the last granted one.
    always_comb begin
        winner = last;
        for (int i = 4; i >= 1; i--) begin
            if (elig[last + 2'(i)]) winner = last + 2'(i);
        end
    end

    // Byte accounting for the granted burst; the count can never pass MAX_BURST.
    always_comb begin
        count_sum = {1'b0, byte_count} + 9'(xfer);
        count_sat = (count_sum >= 9'(MAX_BURST)) ? MAX_B : count_sum[7:0];
        end_cond  = (count_sum == 9'(MAX_BURST)) || !elig[grant_ep];
        // Source ran dry (not the FX2 buffer filling up) on an IN endpoint.
        src_done  = grant_ep[1] && !ep_ready[grant_ep]
                    && !(grant_ep[0] ? usb_ep8_full : usb_ep6_full);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last;
        addr_nx  = usb_addr;
        gep_nx   = grant_ep;
        bc_nx    = byte_count;
        gv_nx    = 1'b0;
        bd_nx    = 1'b0;
        pkt_nx   = 1'b0;
        be_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (|elig) begin
                    state_nx = SETTLE;
                    addr_nx  = winner;
                    gep_nx   = winner;
                    bc_nx    = 8'd0;
                    cnt_nx   = SETTLE_C;
                end
            end
            SETTLE: begin
                if (cnt <= 3'd1) begin
                    if (elig[grant_ep]) begin
                        state_nx = ACTIVE;
                        gv_nx    = 1'b1;
                        bd_nx    = grant_ep[1];
                    end else begin
                        // Winner vanished before the grant: skip it without a burst_end.
                        state_nx = TURN;
                        cnt_nx   = TURN_C;
                        last_nx  = grant_ep;
                    end
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            ACTIVE: begin
                bc_nx = count_sat;
                if (end_cond) begin
                    state_nx = TURN;
                    cnt_nx   = TURN_C;
                    last_nx  = grant_ep;
                    be_nx    = 1'b1;
                    pkt_nx   = src_done && (count_sat != 8'd0) && (count_sat < MAX_B);
                end else begin
                    gv_nx = 1'b1;
                    bd_nx = grant_ep[1];
                end
            end
            TURN: begin
                if (cnt <= 3'd1) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any burst silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            last        <= 2'd3;
            usb_addr    <= 2'd0;
            grant_ep    <= 2'd0;
            grant_valid <= 1'b0;
            bus_drive   <= 1'b0;
            byte_count  <= 8'd0;
            usb_pktend  <= 1'b0;
            burst_end   <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            last        <= last_nx;
            usb_addr    <= addr_nx;
            grant_ep    <= gep_nx;
            grant_valid <= gv_nx;
            bus_drive   <= bd_nx;
            byte_count  <= bc_nx;
            usb_pktend  <= pkt_nx;
            burst_end   <= be_nx;
        end
    end

endmodule
